// File: rtl/rv32_mem_arbiter.sv
// Shares one single-ported memory bus between fetch and mem stages.
// Data wins ties unless fetch has been starved STARVE_LIMIT times.
module rv32_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,
    input  logic        data_valid_in,
    input  logic        data_write_en_in,
    input  logic [31:0] data_address_in,
    input  logic [31:0] data_write_value_in,
    input  logic [3:0]  data_write_mask_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,
    output logic        mem_valid_out,
    output logic [31:0] mem_address_out,
    output logic        mem_write_en_out,
    output logic [31:0] mem_write_value_out,
    output logic [3:0]  mem_write_mask_out,
    input  logic        mem_ready_in,
    input  logic [31:0] mem_read_value_in
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic        instr_ready_q, instr_ready_d;
    logic        data_ready_q, data_ready_d;
    logic [31:0] instr_rdata_q, instr_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        grant_instr;

    // Fetch wins only when alone or when its starvation budget is used up
    assign grant_instr = instr_valid_in &&
                         (!data_valid_in || starve_q == LIMIT);

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = mem_we_q;
        mem_wdata_d   = mem_wdata_q;
        mem_mask_d    = mem_mask_q;
        instr_ready_d = 1'b0;
        data_ready_d  = 1'b0;
        instr_rdata_d = instr_rdata_q;
        data_rdata_d  = data_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_instr) begin
                    state_d     = BUSY_I;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = instr_address_in;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 32'h0;
                    mem_mask_d  = 4'h0;
                    starve_d    = '0;
                end else if (data_valid_in) begin
                    state_d     = BUSY_D;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = data_address_in;
                    mem_we_d    = data_write_en_in;
                    mem_wdata_d = data_write_value_in;
                    mem_mask_d  = data_write_mask_in;
                    if (instr_valid_in && starve_q != LIMIT) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            BUSY_I: begin
                if (mem_ready_in) begin
                    state_d       = DONE;
                    mem_valid_d   = 1'b0;
                    instr_ready_d = 1'b1;
                    instr_rdata_d = mem_read_value_in;
                end
            end
            BUSY_D: begin
                if (mem_ready_in) begin
                    state_d      = DONE;
                    mem_valid_d  = 1'b0;
                    data_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        data_rdata_d = mem_read_value_in;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            starve_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 32'h0;
            mem_mask_q    <= 4'h0;
            instr_ready_q <= 1'b0;
            data_ready_q  <= 1'b0;
            instr_rdata_q <= 32'h0;
            data_rdata_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_mask_q    <= mem_mask_d;
            instr_ready_q <= instr_ready_d;
            data_ready_q  <= data_ready_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign mem_valid_out        = mem_valid_q;
    assign mem_address_out      = mem_addr_q;
    assign mem_write_en_out     = mem_we_q;
    assign mem_write_value_out  = mem_wdata_q;
    assign mem_write_mask_out   = mem_mask_q;
    assign instr_ready_out      = instr_ready_q;
    assign data_ready_out       = data_ready_q;
    assign instr_read_value_out = instr_rdata_q;
    assign data_read_value_out  = data_rdata_q;

endmodule
